// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and a combinational ROM (slave).
interface fetch_unit_if #(
  parameter int unsigned IM_ADDR_W = 10
);
  logic [IM_ADDR_W-1:0] imem_addr;
  logic [31:0]          imem_rdata;

  modport master (output imem_addr, input imem_rdata);
  modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// MIPS fetch stage plus IF/ID register with branch delay slot.
// Define FETCH_NODELAY_EN to replace the delay slot with a one-bubble flush on redirect.
module fetch_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int unsigned IM_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                pcsel,
  input  logic [1:0]          npcsel,
  input  logic [31:0]         rs_d,
  fetch_unit_if.master        imem,
  output logic [31:0]         pc_f,
  output logic [31:0]         instr_d,
  output logic [31:0]         pc_d,
  output logic [31:0]         pc8_d,
  output logic [31:0]         fetch_cnt
);

  logic [31:0] fpc_q, fpc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] dpc_q, dpc_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pd4, br_tgt, j_tgt, jr_tgt, target;

  // Out-of-range PCs simply wrap within the ROM.
  assign imem.imem_addr = IM_ADDR_W'((fpc_q - PC_RESET) >> 2);

  assign pc_f      = fpc_q;
  assign instr_d   = ir_q;
  assign pc_d      = dpc_q;
  assign fetch_cnt = cnt_q;
  assign pc8_d     = dpc_q + 32'd8;

  // Targets come from the instruction held in D, never from the word being fetched.
  assign pd4    = dpc_q + 32'd4;
  assign br_tgt = pd4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  assign j_tgt  = {pd4[31:28], ir_q[25:0], 2'b00};
  assign jr_tgt = rs_d & ~32'h3;

  always_comb begin
    target = br_tgt;
    case (npcsel)
      2'b01:   target = j_tgt;
      2'b10:   target = jr_tgt;
      default: target = br_tgt;
    endcase
  end

  always_comb begin
    fpc_d = fpc_q;
    ir_d  = ir_q;
    dpc_d = dpc_q;
    cnt_d = cnt_q;
    // Under stall the D instruction is held and will re-assert pcsel, so pcsel is ignored.
    if (!stall) begin
      dpc_d = fpc_q;
      fpc_d = pcsel ? target : fpc_q + 32'd4;
`ifdef FETCH_NODELAY_EN
      if (pcsel) begin
        ir_d = 32'h0;
      end else begin
        ir_d  = imem.imem_rdata;
        cnt_d = cnt_q + 32'd1;
      end
`else
      ir_d  = imem.imem_rdata;
      cnt_d = cnt_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q <= PC_RESET;
      ir_q  <= 32'h0;
      dpc_q <= PC_RESET;
      cnt_q <= 32'h0;
    end else begin
      fpc_q <= fpc_d;
      ir_q  <= ir_d;
      dpc_q <= dpc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table for free-run/jr/stall, hand sequences for the rest.
module tb_fetch_unit;

`ifdef FETCH_NODELAY_EN
  localparam bit NoDelay = 1'b1;
`else
  localparam bit NoDelay = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, pcsel;
  logic [1:0]  npcsel;
  logic [31:0] rs_d, pc_f, instr_d, pc_d, pc8_d, fetch_cnt;
  logic [31:0] rom [1024];
  int          n_chk = 0;
  int          n_fail = 0;

  fetch_unit_if #(.IM_ADDR_W(10)) bus ();

  fetch_unit #(.PC_RESET(32'h0000_3000), .IM_ADDR_W(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .pcsel     (pcsel),
    .npcsel    (npcsel),
    .rs_d      (rs_d),
    .imem      (bus),
    .pc_f      (pc_f),
    .instr_d   (instr_d),
    .pc_d      (pc_d),
    .pc8_d     (pc8_d),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;
  always_comb bus.imem_rdata = rom[bus.imem_addr];

  typedef struct {
    logic        rst;
    logic        stl;
    logic        psel;
    logic [1:0]  nsel;
    logic [31:0] rs;
    logic [31:0] e_pcf;
    logic [31:0] e_ir;
    logic [31:0] e_pcd;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic p, input logic [1:0] n,
                       input logic [31:0] rs);
    reset  = r;
    stall  = s;
    pcsel  = p;
    npcsel = n;
    rs_d   = rs;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) rom[k] = 32'h1000_0000 + k;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);

    //           rst   stl   psel  nsel   rs            pc_f          instr_d                           pc_d          cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0,        32'h3000, 32'h0,                              32'h3000, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h3004, 32'h1000_0000,                      32'h3000, 32'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h3008, 32'h1000_0001,                      32'h3004, 32'd2};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h300C, 32'h1000_0002,                      32'h3008, 32'd3};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        32'h3010, 32'h1000_0003,                      32'h300C, 32'd4};
    // jr to 0x3023 -> 0x3020
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_3023, 32'h3020, NoDelay ? 32'h0 : 32'h1000_0004,
                 32'h3010, NoDelay ? 32'd4 : 32'd5};
    // stall with pcsel held: nothing moves
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 32'h0,        32'h3020, NoDelay ? 32'h0 : 32'h1000_0004,
                 32'h3010, NoDelay ? 32'd4 : 32'd5};
    vecs[7]  = vecs[6];
    vecs[8]  = vecs[6];
    // branch released: pd4=0x3014, imm 4 -> 0x3024 (flush build: imm 0 -> 0x3014)
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0,        NoDelay ? 32'h3014 : 32'h3024,
                 NoDelay ? 32'h0 : 32'h1000_0008, 32'h3020, NoDelay ? 32'd4 : 32'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 2'b00, 32'h0,        NoDelay ? 32'h3018 : 32'h3028,
                 NoDelay ? 32'h1000_0005 : 32'h1000_0009, NoDelay ? 32'h3014 : 32'h3024,
                 NoDelay ? 32'd5 : 32'd7};

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].psel, vecs[i].nsel, vecs[i].rs);
      step();
      chk($sformatf("v%0d pc_f", i), pc_f, vecs[i].e_pcf);
      chk($sformatf("v%0d instr_d", i), instr_d, vecs[i].e_ir);
      chk($sformatf("v%0d pc_d", i), pc_d, vecs[i].e_pcd);
      chk($sformatf("v%0d pc8_d", i), pc8_d, vecs[i].e_pcd + 32'd8);
      chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, vecs[i].e_cnt);
      if (i == 0) chk("reset imem_addr", 32'(bus.imem_addr), 32'h0);
    end

    // beq at 0x3004 with imm16 = -1
    rom[1] = 32'h1000_FFFF;
    rom[4] = 32'h0C00_0C40;
    rom[5] = 32'h1000_0002;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    step();
    step();
    chk("beq in D", instr_d, 32'h1000_FFFF);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    step();
    chk("beq pc_f", pc_f, 32'h3004);
    chk("beq slot", instr_d, NoDelay ? 32'h0 : 32'h1000_0002);
    chk("beq pc_d", pc_d, 32'h3008);
    chk("beq cnt", fetch_cnt, NoDelay ? 32'd2 : 32'd3);

    // jal at 0x3010, followed by a branch in its delay slot
    drive(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    repeat (5) step();
    chk("jal in D", instr_d, 32'h0C00_0C40);
    chk("jal pc8_d", pc8_d, 32'h3018);
    drive(1'b0, 1'b0, 1'b1, 2'b01, 32'h0);
    step();
    chk("jal pc_f", pc_f, 32'h3100);
    chk("jal imem_addr", 32'(bus.imem_addr), 32'h40);
    chk("jal slot", instr_d, NoDelay ? 32'h0 : 32'h1000_0002);
    chk("jal pc_d", pc_d, 32'h3014);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 32'h0);
    step();
    chk("b2b pc_f", pc_f, NoDelay ? 32'h3018 : 32'h3020);
    chk("b2b instr_d", instr_d, NoDelay ? 32'h0 : 32'h1000_0040);
    chk("b2b pc_d", pc_d, 32'h3100);

    // reset beats stall and pcsel
    drive(1'b1, 1'b1, 1'b1, 2'b10, 32'h0000_4000);
    step();
    chk("rst pc_f", pc_f, 32'h3000);
    chk("rst instr_d", instr_d, 32'h0);
    chk("rst pc_d", pc_d, 32'h3000);
    chk("rst cnt", fetch_cnt, 32'd0);

    // jr below PC_RESET wraps the ROM address
    drive(1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_2FFC);
    step();
    chk("wrap pc_f", pc_f, 32'h2FFC);
    chk("wrap imem_addr", 32'(bus.imem_addr), 32'h3FF);
    chk("wrap instr_d", instr_d, NoDelay ? 32'h0 : 32'h1000_0000);
    chk("wrap cnt", fetch_cnt, NoDelay ? 32'd0 : 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
